// File: rtl/mavg_mc.sv
// Multi-channel moving-average filter: per-channel N-deep window and running sum,
// one registered average per accepted sample. Define MAVG_ROUND_EN for round-half-up output.
module mavg_mc #(
  parameter  int DW = 16,
  parameter  int N  = 8,
  parameter  int CH = 4,
  localparam int LN = $clog2(N),
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          update_clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ch,
  output logic [DW-1:0] out_data,
  output logic          out_full
);

  localparam int SW = DW + LN;

  logic [DW-1:0] mem_q [CH][N];
  logic [LN-1:0] wp_q  [CH];
  logic [LN:0]   cnt_q [CH];
  logic [SW-1:0] sum_q [CH];

  logic          out_valid_q;
  logic [CW-1:0] out_ch_q;
  logic [DW-1:0] out_data_q;
  logic          out_full_q;

  logic          ch_ok_s;
  logic [CW-1:0] ch_s;
  logic          acc_s;
  logic          win_full_s;
  logic [DW-1:0] drop_s;
  logic [SW-1:0] sum_d;
  logic [LN:0]   cnt_d;
  logic [DW-1:0] avg_s;

  assign ch_ok_s  = ({1'b0, in_ch} < (CW+1)'(CH));
  assign ch_s     = ch_ok_s ? in_ch : '0;
  assign in_ready = (!out_valid_q || out_ready) && !clear;
  assign acc_s    = in_valid && in_ready && ch_ok_s;

  // Forwarded next-state of the addressed channel, so back-to-back samples see the new sum
  always_comb begin
    win_full_s = (cnt_q[ch_s] == (LN+1)'(N));
    drop_s     = win_full_s ? mem_q[ch_s][wp_q[ch_s]] : '0;
    sum_d      = sum_q[ch_s] + {{LN{in_data[DW-1]}}, in_data} - {{LN{drop_s[DW-1]}}, drop_s};
    cnt_d      = win_full_s ? cnt_q[ch_s] : cnt_q[ch_s] + (LN+1)'(1);
  end

`ifdef MAVG_ROUND_EN
  localparam logic [SW:0] HALF = (SW+1)'(1) << (LN - 1);
  logic [SW:0] rnd_s;
  logic        unused_rnd_s;
  assign rnd_s        = {sum_d[SW-1], sum_d} + HALF;
  assign avg_s        = rnd_s[SW-1:LN];
  assign unused_rnd_s = ^{rnd_s[SW], rnd_s[LN-1:0]};
`else
  // Selecting bits above LN is the arithmetic shift; the result always fits DW
  assign avg_s = sum_d[SW-1:LN];
`endif

  // Sample storage is never reset; cnt masks stale entries
  always_ff @(posedge update_clk) begin
    if (acc_s) begin
      mem_q[ch_s][wp_q[ch_s]] <= in_data;
    end
  end

  // Per-channel pointer, count and running sum
  always_ff @(posedge update_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        wp_q[c]  <= '0;
        cnt_q[c] <= '0;
        sum_q[c] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CH; c++) begin
        wp_q[c]  <= '0;
        cnt_q[c] <= '0;
        sum_q[c] <= '0;
      end
    end else if (acc_s) begin
      wp_q[ch_s]  <= wp_q[ch_s] + LN'(1);
      cnt_q[ch_s] <= cnt_d;
      sum_q[ch_s] <= sum_d;
    end
  end

  // Output register: load on accept, drop valid once the consumer takes it
  always_ff @(posedge update_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_full_q  <= 1'b0;
    end else if (acc_s) begin
      out_valid_q <= 1'b1;
      out_ch_q    <= ch_s;
      out_data_q  <= avg_s;
      out_full_q  <= (cnt_d == (LN+1)'(N));
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_full  = out_full_q;

endmodule

// File: tb/tb_mavg_mc.sv
// Directed bench for mavg_mc with N=4, CH=2, DW=16.
module tb_mavg_mc;

  logic        update_clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_ch;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_ch;
  logic [15:0] out_data;
  logic        out_full;

  int n_chk  = 0;
  int n_pass = 0;

  mavg_mc #(.DW(16), .N(4), .CH(2)) dut (
    .update_clk (update_clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .out_full   (out_full)
  );

  initial begin
    update_clk = 1'b0;
    forever #5 update_clk = ~update_clk;
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic push(input int ch, input int d, input int exp_d, input int exp_full);
    @(negedge update_clk);
    in_valid  = 1'b1;
    in_ch     = 1'(ch);
    in_data   = 16'(d);
    out_ready = 1'b1;
    #1 check("in_ready", in_ready, 1);
    @(posedge update_clk);
    #1 in_valid = 1'b0;
    check("out_valid", out_valid, 1);
    check("out_ch", out_ch, ch);
    check("out_data", $signed(out_data), exp_d);
    check("out_full", out_full, exp_full);
  endtask

  task automatic do_clear();
    @(negedge update_clk);
    clear    = 1'b1;
    in_valid = 1'b0;
    #1 check("clear_in_ready", in_ready, 0);
    @(posedge update_clk);
    #1 clear = 1'b0;
  endtask

`ifdef MAVG_ROUND_EN
  localparam int NEG1_EXP = 0;
  int max_exp [4] = '{8192, 16384, 24575, 32767};
`else
  localparam int NEG1_EXP = -1;
  int max_exp [4] = '{8191, 16383, 24575, 32767};
`endif
  int fill_exp  [5] = '{1, 3, 6, 10, 14};
  int fill_full [5] = '{0, 0, 0, 1, 1};
  int min_exp   [4] = '{-8192, -16384, -24576, -32768};

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_ch = 1'b0; in_data = 16'd123; out_ready = 1'b1;
    repeat (3) @(posedge update_clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", $signed(out_data), 0);
    check("rst_out_full", out_full, 0);
    check("rst_out_ch", out_ch, 0);
    @(negedge update_clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 5; i++) push(0, 4 * (i + 1), fill_exp[i], fill_full[i]);

    do_clear();
    for (int i = 0; i < 4; i++) begin
      push(0, 100, 25 * (i + 1), (i == 3) ? 1 : 0);
      push(1, -100, -25 * (i + 1), (i == 3) ? 1 : 0);
    end

    do_clear();
    push(0, -1, NEG1_EXP, 0);
    do_clear();
    for (int i = 0; i < 4; i++) push(0, 32767, max_exp[i], (i == 3) ? 1 : 0);
    do_clear();
    for (int i = 0; i < 4; i++) push(1, -32768, min_exp[i], (i == 3) ? 1 : 0);

    do_clear();
    @(negedge update_clk);
    in_valid = 1'b1; in_ch = 1'b0; in_data = 16'd4; out_ready = 1'b0;
    @(posedge update_clk);
    #1 in_data = 16'd8;
    check("bp_first_valid", out_valid, 1);
    check("bp_first_data", $signed(out_data), 1);
    repeat (3) begin
      @(negedge update_clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_data", $signed(out_data), 1);
      check("bp_hold_valid", out_valid, 1);
    end
    @(negedge update_clk);
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    @(posedge update_clk);
    #1 in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_data", $signed(out_data), 3);
    check("bp_second_full", out_full, 0);
    @(posedge update_clk);
    #1 check("bp_drain_valid", out_valid, 0);

    do_clear();
    push(0, 40, 10, 0);
    push(0, 40, 20, 0);
    @(negedge update_clk);
    clear = 1'b1; in_valid = 1'b1; in_ch = 1'b0; in_data = 16'd99;
    #1 check("clr_vs_in_ready", in_ready, 0);
    @(posedge update_clk);
    #1 begin clear = 1'b0; in_valid = 1'b0; end
    push(0, 8, 2, 0);

    push(0, 40, 12, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", $signed(out_data), 0);
    check("midrst_out_full", out_full, 0);
    @(negedge update_clk);
    rst_n = 1'b1;
    push(0, 4, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
